// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM write-side blocks: FSM encoding and
// default video frame geometry.
package sdram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_RST,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int DEF_H_PIXELS = 640;
    localparam int DEF_V_LINES  = 480;
    localparam int DEF_RST_CYC  = 4;

    function automatic int words_per_frame(input int h, input int v);
        return (h * v) / 2;
    endfunction

endpackage

// File: rtl/sdram_wr_packer.sv
// Packs RGB565 pixel pairs into 32-bit write-FIFO words, frames each write
// pass with a wr_rst pulse and reports frame completion or abort.
module sdram_wr_packer
    import sdram_pkg::*;
#(
    parameter int H_PIXELS = DEF_H_PIXELS,
    parameter int V_LINES  = DEF_V_LINES,
    parameter int RST_CYC  = DEF_RST_CYC
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end,
    input  logic        pix_sof,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        wr_fifo_wr_req,
    output logic [31:0] wr_fifo_wr_data,
    output logic        wr_rst,
    output logic        read_valid,
    output logic        frame_done,
    output logic        frame_short,
    output logic [7:0]  frame_cnt
);

    localparam int WORDS  = words_per_frame(H_PIXELS, V_LINES);
    localparam int WCNT_W = $clog2(WORDS + 1);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS - 1);
    localparam logic [3:0]        RST_LAST  = 4'(RST_CYC - 1);

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          rst_cnt;
    logic [WCNT_W-1:0]   word_cnt;
    logic [15:0]         half;
    logic                half_vld;
    logic                accept;
    logic                pair_done;
    logic                last_pair;
    logic                sof_abort;

    // A pix_sof that coincides with the final pixel loses to frame completion.
    always_comb begin
        accept    = (state == ST_RUN) && pix_valid;
        pair_done = accept && half_vld;
        last_pair = pair_done && (word_cnt == LAST_WORD);
        sof_abort = (state == ST_RUN) && pix_sof && !last_pair;
    end

    always_comb begin
        state_nxt = state;
        if (!init_end) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     state_nxt = ST_WAIT_SOF;
                ST_WAIT_SOF: if (pix_sof) state_nxt = ST_RST;
                ST_RST:      if (!pix_sof && (rst_cnt == RST_LAST)) state_nxt = ST_RUN;
                ST_RUN: begin
                    if (last_pair)      state_nxt = ST_DONE;
                    else if (pix_sof)   state_nxt = ST_RST;
                end
                ST_DONE:     state_nxt = ST_WAIT_SOF;
                default:     state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= ST_IDLE;
            rst_cnt <= 4'd0;
        end else begin
            state   <= state_nxt;
            rst_cnt <= (state == ST_RST && state_nxt == ST_RST && !pix_sof) ? rst_cnt + 4'd1 : 4'd0;
        end
    end

    assign wr_rst = (state == ST_RST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            word_cnt        <= '0;
            half            <= 16'd0;
            half_vld        <= 1'b0;
            wr_fifo_wr_req  <= 1'b0;
            wr_fifo_wr_data <= 32'd0;
            read_valid      <= 1'b0;
            frame_done      <= 1'b0;
            frame_short     <= 1'b0;
            frame_cnt       <= 8'd0;
        end else begin
            wr_fifo_wr_req <= 1'b0;
            frame_done     <= 1'b0;
            frame_short    <= 1'b0;
            if (!init_end) begin
                word_cnt   <= '0;
                half       <= 16'd0;
                half_vld   <= 1'b0;
                read_valid <= 1'b0;
            end else if (sof_abort) begin
                word_cnt    <= '0;
                half        <= 16'd0;
                half_vld    <= 1'b0;
                frame_short <= 1'b1;
            end else if (pair_done) begin
                wr_fifo_wr_req  <= 1'b1;
                wr_fifo_wr_data <= {half, pix_data};
                half_vld        <= 1'b0;
                if (last_pair) begin
                    word_cnt   <= '0;
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 8'd1;
                    read_valid <= 1'b1;
                end else begin
                    word_cnt <= word_cnt + WCNT_W'(1);
                end
            end else if (accept) begin
                half     <= pix_data;
                half_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_wr_packer.sv
// Bench for sdram_wr_packer: frame-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_sdram_wr_packer;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int RC   = 2;
    localparam int NPIX = H * V;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        init_end;
    logic        pix_sof;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        wr_fifo_wr_req;
    logic [31:0] wr_fifo_wr_data;
    logic        wr_rst;
    logic        read_valid;
    logic        frame_done;
    logic        frame_short;
    logic [7:0]  frame_cnt;

    sdram_wr_packer #(.H_PIXELS(H), .V_LINES(V), .RST_CYC(RC)) dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .init_end        (init_end),
        .pix_sof         (pix_sof),
        .pix_valid       (pix_valid),
        .pix_data        (pix_data),
        .wr_fifo_wr_req  (wr_fifo_wr_req),
        .wr_fifo_wr_data (wr_fifo_wr_data),
        .wr_rst          (wr_rst),
        .read_valid      (read_valid),
        .frame_done      (frame_done),
        .frame_short     (frame_short),
        .frame_cnt       (frame_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the phase of the frame and the list of pixels
    // accepted so far in the current frame.
    typedef enum {M_IDLE, M_WAIT, M_RST, M_RUN, M_DONE} mphase_t;
    mphase_t     ph = M_IDLE;
    int          rst_left = 0;
    logic [15:0] frame_pix[$];
    logic        e_req = 0, e_rst = 0, e_rv = 0, e_done = 0, e_short = 0;
    logic [31:0] e_data = 0;
    logic [7:0]  e_cnt = 0;

    task automatic model_step();
        bit fin;
        e_req = 0; e_done = 0; e_short = 0;
        if (!init_end) begin
            ph = M_IDLE;
            frame_pix.delete();
            e_rv = 0;
        end else begin
            case (ph)
                M_IDLE: ph = M_WAIT;
                M_WAIT: if (pix_sof) begin ph = M_RST; rst_left = RC; end
                M_RST: begin
                    if (pix_sof) rst_left = RC;
                    else begin
                        rst_left--;
                        if (rst_left == 0) ph = M_RUN;
                    end
                end
                M_RUN: begin
                    fin = pix_valid && (frame_pix.size() == NPIX - 1);
                    if (pix_sof && !fin) begin
                        e_short = 1;
                        frame_pix.delete();
                        ph = M_RST;
                        rst_left = RC;
                    end else if (pix_valid) begin
                        frame_pix.push_back(pix_data);
                        if (frame_pix.size() % 2 == 0) begin
                            e_req  = 1;
                            e_data = {frame_pix[frame_pix.size()-2], frame_pix[frame_pix.size()-1]};
                        end
                        if (fin) begin
                            e_done = 1;
                            e_cnt  = e_cnt + 8'd1;
                            e_rv   = 1;
                            frame_pix.delete();
                            ph = M_DONE;
                        end
                    end
                end
                default: ph = M_WAIT;
            endcase
        end
        e_rst = (ph == M_RST);
    endtask

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ph = M_IDLE; frame_pix.delete();
            e_req = 0; e_rst = 0; e_rv = 0; e_done = 0; e_short = 0;
            e_data = 0; e_cnt = 0;
        end else begin
            model_step();
        end
    end

    always @(negedge sys_clk) begin
        chk("wr_req", {31'd0, wr_fifo_wr_req}, {31'd0, e_req});
        if (e_req) chk("wr_data", wr_fifo_wr_data, e_data);
        chk("wr_rst", {31'd0, wr_rst}, {31'd0, e_rst});
        chk("read_valid", {31'd0, read_valid}, {31'd0, e_rv});
        chk("frame_done", {31'd0, frame_done}, {31'd0, e_done});
        chk("frame_short", {31'd0, frame_short}, {31'd0, e_short});
        chk("frame_cnt", {24'd0, frame_cnt}, {24'd0, e_cnt});
    end

    // Observation log used by the directed checks.
    logic [31:0] got_words[$];
    int rst_cycles = 0, done_seen = 0, short_seen = 0;

    always @(negedge sys_clk) begin
        if (wr_fifo_wr_req) got_words.push_back(wr_fifo_wr_data);
        if (wr_rst)         rst_cycles++;
        if (frame_done)     done_seen++;
        if (frame_short)    short_seen++;
    end

    task automatic clear_log();
        got_words.delete();
        rst_cycles = 0; done_seen = 0; short_seen = 0;
    endtask

    task automatic cyc(input bit sof, input bit vld, input logic [15:0] d);
        pix_sof = sof; pix_valid = vld; pix_data = d;
        @(negedge sys_clk); #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 16'd0);
    endtask

    task automatic send_frame(input logic [15:0] base, input int gap, input bit rnd);
        cyc(1, 0, 16'd0);
        idle(RC);
        for (int i = 0; i < NPIX; i++) begin
            cyc(0, 1, rnd ? 16'($urandom) : base + 16'(i));
            idle(rnd ? $urandom_range(0, 2) : gap);
        end
        idle(2);
    endtask

    task automatic chk_frame_words(input string tag);
        chk({tag, "_nwords"}, 32'(got_words.size()), 32'd4);
        if (got_words.size() == 4) begin
            chk({tag, "_w0"}, got_words[0], 32'h0001_0002);
            chk({tag, "_w1"}, got_words[1], 32'h0003_0004);
            chk({tag, "_w2"}, got_words[2], 32'h0005_0006);
            chk({tag, "_w3"}, got_words[3], 32'h0007_0008);
        end
    endtask

    initial begin
        logic [7:0] cnt0;
        int nw;
        sys_rst_n = 0; init_end = 0; pix_sof = 0; pix_valid = 0; pix_data = 0;
        @(negedge sys_clk); #2;
        idle(2);
        chk("rst_wr_req", {31'd0, wr_fifo_wr_req}, 32'd0);
        chk("rst_wr_data", wr_fifo_wr_data, 32'd0);
        chk("rst_wr_rst", {31'd0, wr_rst}, 32'd0);
        chk("rst_read_valid", {31'd0, read_valid}, 32'd0);
        chk("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        sys_rst_n = 1;
        idle(1);

        // Pixels before any pix_sof: during init, then in WAIT_SOF.
        clear_log();
        for (int i = 0; i < 3; i++) cyc(0, 1, 16'hAA00 + 16'(i));
        init_end = 1;
        for (int i = 0; i < 6; i++) cyc(0, 1, 16'hBB00 + 16'(i));
        chk("early_no_writes", 32'(got_words.size()), 32'd0);

        // Back-to-back frame.
        clear_log();
        send_frame(16'h0001, 0, 0);
        chk("a_wr_rst_cycles", 32'(rst_cycles), 32'd2);
        chk_frame_words("a");
        chk("a_done_pulses", 32'(done_seen), 32'd1);
        chk("a_frame_cnt", {24'd0, frame_cnt}, 32'd1);
        chk("a_read_valid", {31'd0, read_valid}, 32'd1);

        // One pixel every three cycles.
        clear_log();
        send_frame(16'h0001, 2, 0);
        chk_frame_words("b");
        chk("b_frame_cnt", {24'd0, frame_cnt}, 32'd2);

        // Abort after five pixels.
        clear_log();
        cyc(1, 0, 16'd0);
        idle(RC);
        for (int i = 0; i < 5; i++) cyc(0, 1, 16'h0011 + 16'(i));
        rst_cycles = 0;
        cyc(1, 0, 16'd0);
        idle(RC);
        chk("c_words_before_abort", 32'(got_words.size()), 32'd2);
        chk("c_short_pulses", 32'(short_seen), 32'd1);
        chk("c_frame_cnt_kept", {24'd0, frame_cnt}, 32'd2);
        chk("c_wr_rst_repulse", 32'(rst_cycles), 32'd2);
        for (int i = 0; i < NPIX; i++) cyc(0, 1, 16'h0021 + 16'(i));
        idle(2);
        chk("c_nwords", 32'(got_words.size()), 32'd6);
        if (got_words.size() >= 3) chk("c_new_first_word", got_words[2], 32'h0021_0022);
        chk("c_frame_cnt", {24'd0, frame_cnt}, 32'd3);

        // init_end dropped mid-frame.
        clear_log();
        cyc(1, 0, 16'd0);
        idle(RC);
        for (int i = 0; i < 3; i++) cyc(0, 1, 16'h0031 + 16'(i));
        init_end = 0;
        cyc(0, 1, 16'h0034);
        chk("d_read_valid_cleared", {31'd0, read_valid}, 32'd0);
        chk("d_wr_rst_low", {31'd0, wr_rst}, 32'd0);
        nw = got_words.size();
        chk("d_words_before_drop", 32'(nw), 32'd1);
        init_end = 1;
        for (int i = 0; i < 6; i++) cyc(0, 1, 16'h0040 + 16'(i));
        chk("d_no_writes_without_sof", 32'(got_words.size()), 32'(nw));
        chk("d_frame_cnt_kept", {24'd0, frame_cnt}, 32'd3);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            init_end = ($urandom_range(0, 99) != 0);
            cyc($urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0, 16'($urandom));
        end

        // Asynchronous reset while running.
        init_end = 1;
        idle(2);
        send_frame(16'h0051, 0, 0);
        cyc(1, 0, 16'd0);
        idle(RC);
        for (int i = 0; i < 3; i++) cyc(0, 1, 16'h0061 + 16'(i));
        chk("f_running_wr_req", {31'd0, wr_fifo_wr_req}, 32'd0);
        chk("f_running_read_valid", {31'd0, read_valid}, 32'd1);
        #1 sys_rst_n = 0;
        #1;
        chk("f_async_wr_req", {31'd0, wr_fifo_wr_req}, 32'd0);
        chk("f_async_wr_data", wr_fifo_wr_data, 32'd0);
        chk("f_async_wr_rst", {31'd0, wr_rst}, 32'd0);
        chk("f_async_read_valid", {31'd0, read_valid}, 32'd0);
        chk("f_async_frame_done", {31'd0, frame_done}, 32'd0);
        chk("f_async_frame_short", {31'd0, frame_short}, 32'd0);
        chk("f_async_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        @(negedge sys_clk); #2;
        idle(1);
        sys_rst_n = 1;
        idle(2);

        // 256 complete frames with random pixels and gaps.
        clear_log();
        cnt0 = frame_cnt;
        chk("e_start_cnt", {24'd0, cnt0}, 32'd0);
        for (int f = 0; f < 256; f++) begin
            send_frame(16'd0, 0, 1);
            if (f == 254) chk("e_cnt_255", {24'd0, frame_cnt}, 32'd255);
        end
        chk("e_cnt_wrapped", {24'd0, frame_cnt}, 32'd0);
        chk("e_done_pulses", 32'(done_seen), 32'd256);
        chk("e_word_total", 32'(got_words.size()), 32'd1024);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
